// File: rtl/tff_count_sequencer_pkg.sv
// Shared definitions for the toggle flip-flop count sequencer:
// state encoding, default parameters and a counter-width helper.
package tff_count_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_CLEAR = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_MODULUS  = 10;
  localparam int DEF_PRESCALE = 4;

  // A prescale of 1 still needs a one-bit counter so the vector is never empty.
  function automatic int cnt_width(input int prescale);
    if (prescale > 1) begin
      return $clog2(prescale);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/tff_count_sequencer_if.sv
// Control/status bundle between the sequencer and its environment
// (run requests, flop bank feedback, toggle enables and status).
interface tff_count_sequencer_if
  import tff_count_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             stop;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_en;
  logic             t_rst;
  logic             carry;
  logic             running;

  modport slave (
    input  start, stop, clr, q,
    output t_en, t_rst, carry, running
  );

  modport master (
    output start, stop, clr, q,
    input  t_en, t_rst, carry, running
  );

endinterface

// File: rtl/tff_count_sequencer_tick_prescaler.sv
// Free-running divider that emits one tick every PRESCALE enabled cycles;
// holds while disabled and can be synchronously zeroed.
module tick_prescaler
  import tff_count_sequencer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic zero,
  output logic tick
);

  localparam int            CW   = cnt_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_r;

  assign tick = en && (count_r == LAST);

  // Prescale counter: zero has priority, then advance/wrap when enabled, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (zero) begin
      count_r <= '0;
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/tff_count_sequencer.sv
// Run/pause/clear sequencer that drives an external bank of toggle flip-flops
// as a modulo-MODULUS counter, advancing once per prescaler tick.
module tff_count_sequencer
  import tff_count_sequencer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input logic                  clk,
  input logic                  reset,
  tff_count_sequencer_if.slave bus
);

  localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);

  seq_state_t       state_r;
  logic             running_r;
  logic             tick_s;
  logic             wrap_s;
  logic [WIDTH-1:0] inc_en_s;
  logic [WIDTH-1:0] t_en_s;
  logic             t_rst_s;
  logic             carry_s;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state_r == ST_RUN),
    .zero  ((state_r == ST_IDLE) || (state_r == ST_CLEAR)),
    .tick  (tick_s)
  );

  // Sequencer FSM; running is registered alongside the state it reflects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      running_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.clr) begin
            state_r   <= ST_CLEAR;
            running_r <= 1'b0;
          end else if (bus.start && !bus.stop) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.clr) begin
            state_r   <= ST_CLEAR;
            running_r <= 1'b0;
          end else if (bus.stop) begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end else begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end
        end
        ST_PAUSE: begin
          if (bus.clr) begin
            state_r   <= ST_CLEAR;
            running_r <= 1'b0;
          end else if (bus.start && !bus.stop) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= ST_PAUSE;
            running_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Binary increment expressed as toggles: bit i flips when all lower bits are one.
  always_comb begin
    logic chain;
    inc_en_s = '0;
    chain    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_en_s[i] = chain;
      chain       = chain & bus.q[i];
    end
  end

  // Out-of-range values are folded into the wrap case.
  assign wrap_s = ({1'b0, bus.q} >= LAST);

  // Bank control; reset overrides everything so a pending tick is discarded.
  always_comb begin
    t_en_s  = '0;
    t_rst_s = 1'b0;
    carry_s = 1'b0;
    if (reset) begin
      t_rst_s = 1'b1;
    end else if (state_r == ST_CLEAR) begin
      t_rst_s = 1'b1;
    end else if (tick_s) begin
      if (wrap_s) begin
        t_rst_s = 1'b1;
        carry_s = 1'b1;
      end else begin
        t_en_s = inc_en_s;
      end
    end else begin
      t_en_s  = '0;
      t_rst_s = 1'b0;
      carry_s = 1'b0;
    end
  end

  assign bus.t_en    = t_en_s;
  assign bus.t_rst   = t_rst_s;
  assign bus.carry   = carry_s;
  assign bus.running = running_r;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed plus randomized bench for tff_count_sequencer driving real toggle-flop
// banks, checked against a cycle-level count/mode reference model.
module tb_tff_count_sequencer;

  localparam int W = 4;
  localparam int M = 10;
  localparam int P = 4;

  localparam int MD_IDLE  = 100;
  localparam int MD_RUN   = 101;
  localparam int MD_PAUSE = 102;
  localparam int MD_CLEAR = 103;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  tff_count_sequencer_if #(.WIDTH(W)) b1 ();
  tff_count_sequencer_if #(.WIDTH(W)) b2 ();

  tff_count_sequencer #(.WIDTH(W), .MODULUS(M), .PRESCALE(P)) dut1 (
    .clk (clk), .reset (reset), .bus (b1)
  );

  tff_count_sequencer #(.WIDTH(W), .MODULUS(16), .PRESCALE(1)) dut2 (
    .clk (clk), .reset (reset2), .bus (b2)
  );

  for (genvar i = 0; i < W; i++) begin : g_bank
    logic qa;
    logic qb;
    always_ff @(posedge clk) begin
      if (b1.t_rst) qa <= 1'b0;
      else if (b1.t_en[i]) qa <= ~qa;
      else qa <= qa;
    end
    always_ff @(posedge clk) begin
      if (b2.t_rst) qb <= 1'b0;
      else if (b2.t_en[i]) qb <= ~qb;
      else qb <= qb;
    end
    assign b1.q[i] = qa;
    assign b2.q[i] = qb;
  end

  int checks  = 0;
  int passes  = 0;
  int carries = 0;
  int m_mode, m_pc, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    bit tk, wr;
    int te;
    tk = !reset && (m_mode == MD_RUN) && (m_pc == P - 1);
    wr = tk && (m_cnt >= M - 1);
    te = (tk && !wr) ? ((m_cnt ^ (m_cnt + 1)) & ((1 << W) - 1)) : 0;
    chk("q", b1.q, m_cnt);
    chk("t_en", b1.t_en, te);
    chk("t_rst", b1.t_rst, reset || (m_mode == MD_CLEAR) || wr);
    chk("carry", b1.carry, wr);
    chk("running", b1.running, !reset && (m_mode == MD_RUN));
    if (b1.carry === 1'b1) carries++;
  endtask

  task automatic advance();
    bit tk;
    if (reset) begin
      m_mode = MD_IDLE; m_pc = 0; m_cnt = 0;
    end else begin
      tk = (m_mode == MD_RUN) && (m_pc == P - 1);
      if (m_mode == MD_CLEAR) m_cnt = 0;
      else if (tk) m_cnt = (m_cnt >= M - 1) ? 0 : m_cnt + 1;
      if (m_mode == MD_RUN) m_pc = tk ? 0 : m_pc + 1;
      else if (m_mode != MD_PAUSE) m_pc = 0;
      if (m_mode == MD_CLEAR) m_mode = MD_IDLE;
      else if (b1.clr) m_mode = MD_CLEAR;
      else if (m_mode == MD_RUN) begin
        if (b1.stop) m_mode = MD_PAUSE;
      end else if (b1.start && !b1.stop) m_mode = MD_RUN;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic set_in(input logic s, input logic p, input logic c);
    b1.start = s; b1.stop = p; b1.clr = c;
  endtask

  initial begin
    int c0;
    reset = 1'b1; reset2 = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    b2.start = 1'b0; b2.stop = 1'b0; b2.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_mode = MD_IDLE; m_pc = 0; m_cnt = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Continuous count 0..9 with exactly one carry across 40 run cycles
    set_in(1'b1, 1'b0, 1'b0);
    carries = 0;
    repeat (41) cyc();
    chk("carry_count_full", carries, 1);
    chk("q_after_wrap", b1.q, 0);

    // Pause at q=5 with prescaler at 2, then resume
    for (int n = 0; n < 200 && !(m_mode == MD_RUN && m_cnt == 5 && m_pc == 2); n++) cyc();
    chk("q_at_stop", b1.q, 5);
    set_in(1'b0, 1'b1, 1'b0);
    repeat (7) cyc();
    chk("q_paused", b1.q, 5);
    chk("running_paused", b1.running, 0);
    set_in(1'b1, 1'b0, 1'b0);
    cyc();
    chk("q_resume_1", b1.q, 5);
    cyc();
    chk("q_resume_2", b1.q, 6);

    // Clear while running at q=7
    for (int n = 0; n < 200 && !(m_mode == MD_RUN && m_cnt == 7); n++) cyc();
    chk("q_before_clr", b1.q, 7);
    set_in(1'b1, 1'b0, 1'b1);
    cyc();
    set_in(1'b0, 1'b0, 1'b0);
    #2;
    chk("t_rst_in_clear", b1.t_rst, 1);
    cyc();
    chk("q_cleared", b1.q, 0);
    chk("running_cleared", b1.running, 0);

    // All three requests together while paused: clear wins
    set_in(1'b1, 1'b0, 1'b0);
    repeat (6) cyc();
    set_in(1'b0, 1'b1, 1'b0);
    cyc(); cyc();
    chk("running_pause_38", b1.running, 0);
    set_in(1'b1, 1'b1, 1'b1);
    cyc();
    set_in(1'b0, 1'b0, 1'b0);
    #2;
    chk("t_rst_clear_38", b1.t_rst, 1);
    cyc();
    chk("q_clear_38", b1.q, 0);

    // Randomized request traffic
    for (int n = 0; n < 300; n++) begin
      set_in(1'($urandom_range(1, 0)), 1'($urandom_range(5, 0) == 0), 1'($urandom_range(19, 0) == 0));
      cyc();
    end

    // Asynchronous reset in the middle of the wrapping tick at q=9
    set_in(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 200 && !(m_mode == MD_RUN && m_cnt == M - 1 && m_pc == P - 1); n++) cyc();
    chk("q_at_9", b1.q, 9);
    c0 = carries;
    #2;
    reset = 1'b1;
    #1;
    chk("t_rst_async", b1.t_rst, 1);
    chk("t_en_async", b1.t_en, 0);
    chk("carry_async", b1.carry, 0);
    chk("running_async", b1.running, 0);
    cyc();
    chk("q_after_reset", b1.q, 0);
    chk("no_carry_reset", carries, c0);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    cyc(); cyc();

    // Full binary range with prescale 1 on the second instance
    b2.start = 1'b1;
    reset2 = 1'b0;
    for (int j = 0; j < 36; j++) begin
      int eq;
      eq = (j >= 1) ? (j - 1) % 16 : 0;
      @(negedge clk);
      chk("q_p1", b2.q, eq);
      chk("carry_p1", b2.carry, (j >= 1) && (eq == 15));
      chk("running_p1", b2.running, j >= 1);
      if (j >= 1 && eq == 7) chk("t_en_at_7", b2.t_en, 4'b1111);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tff_count_sequencer.md
TFF_COUNT_SEQUENCER -- requirements
Module: tff_count_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, number of toggle flip-flops in the controlled bank.
REQ-002 Parameter MODULUS, default 10, count modulus; legal range 2..2^WIDTH.
REQ-003 Parameter PRESCALE, default 4, clk cycles per count tick; legal range >= 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level; request to run counting.
REQ-007 stop  input  1  level; request to pause counting.
REQ-008 clr  input  1  level; synchronous request to clear the bank to zero.
REQ-009 q  input  WIDTH  current Q outputs of the flip-flop bank, bit 0 = LSB.
REQ-010 t_en  output  WIDTH  per-flop toggle enable; bit i drives enable of flop i.
REQ-011 t_rst  output  1  bank synchronous reset; drives reset of every flop.
REQ-012 carry  output  1  one-cycle pulse on wrap from MODULUS-1 to 0.
REQ-013 running  output  1  high while state is RUN.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSE, CLEAR.
REQ-015 IDLE -> RUN on start; IDLE -> CLEAR on clr; otherwise hold.
REQ-016 RUN -> PAUSE on stop; RUN -> CLEAR on clr; otherwise hold.
REQ-017 PAUSE -> RUN on start with stop low; PAUSE -> CLEAR on clr; otherwise hold.
REQ-018 CLEAR SHALL last exactly one cycle, then go to IDLE.
REQ-019 Priority on simultaneous inputs: clr > stop > start.
REQ-020 Prescaler counter 0..PRESCALE-1 SHALL advance only in RUN; tick = (prescaler == PRESCALE-1) and state RUN; prescaler wraps to 0 on tick.
REQ-021 Prescaler SHALL hold value in PAUSE and SHALL be zeroed in IDLE and CLEAR.
REQ-022 On tick with q != MODULUS-1: t_en[0] = 1, t_en[i] = AND of q[i-1:0] for i > 0 (binary increment via toggles).
REQ-023 On tick with q == MODULUS-1: t_en = 0, t_rst = 1, carry = 1 for that cycle (wrap to 0).
REQ-024 In CLEAR: t_rst = 1, t_en = 0, carry = 0.
REQ-025 All other cycles: t_en = 0, t_rst = 0, carry = 0.
REQ-026 t_en, t_rst, carry SHALL be combinational from registered state, prescaler and q; bank changes on the same edge the tick is seen (zero-cycle latency, one increment per tick).
REQ-027 If q >= MODULUS on a tick (out-of-range after external disturbance), behaviour SHALL equal the wrap case of REQ-023.
REQ-028 PRESCALE = 1 SHALL tick every RUN cycle.

Reset
REQ-029 Asserting reset SHALL immediately force state IDLE, prescaler 0; outputs t_en = 0, carry = 0, running = 0, t_rst = 1 while reset is high.
REQ-030 On release, first edge: t_rst = 0, state IDLE; bank assumed cleared by the reset-time t_rst.
REQ-031 Reset mid-RUN SHALL abort any pending tick; no carry is emitted.

Structure
REQ-032 Shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, CLEAR=2'd3) and default parameter constants.
REQ-033 One sub-module tick_prescaler (counter, enable, sync zero, tick output) SHALL be instantiated; FSM and enable logic stay in the top.
REQ-034 Bench SHALL instantiate WIDTH toggle flip-flops driven by t_en/t_rst with q fed back.

Verification
REQ-035 Reset, start=1 held, PRESCALE=4, MODULUS=10 -> q increments every 4 cycles 0..9, carry pulses once at 9->0 after 40 cycles.
REQ-036 RUN at q=5, prescaler=2, stop for 7 cycles then start -> q stays 5, next increment 2 cycles after resume.
REQ-037 clr=1 while RUN at q=7 -> one CLEAR cycle with t_rst=1, q=0, state IDLE, running=0.
REQ-038 start, stop, clr asserted together in PAUSE -> CLEAR taken, q=0.
REQ-039 reset asserted asynchronously mid-cycle during tick at q=9 -> no carry, q=0, outputs per REQ-029 before next edge.
REQ-040 MODULUS=16, WIDTH=4, PRESCALE=1 -> q counts 0..15, wraps to 0 with carry every 16 cycles; t_en=4'b1111 at q=7.
